bcd_serial_addsub: RTL



---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_digit_addsub.sv | 31 +++
 rtl/bcd_serial_addsub.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder/subtractor.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_CORR = 4'd6;

  // True when a nibble is not a legal decimal digit.
  function automatic logic digit_invalid(input bcd_digit_t d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// Single-digit BCD add/subtract stage, time-shared across all digits by the top level.
// Latency: purely combinational.
// Backpressure: none; the caller sequences the digits.
module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  input  logic       sub,
  output bcd_digit_t digit,
  output logic       cout
);

  bcd_digit_t b_eff;
  logic [4:0] t;

  // Nine's-complement B in subtract mode, binary-add, then decimal-correct.
  always_comb begin
    b_eff = sub ? (BCD_MAX - b) : b;
    t     = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
    if (t > {1'b0, BCD_MAX}) begin
      digit = t[3:0] + BCD_CORR;
      cout  = 1'b1;
    end else begin
      digit = t[3:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD A+B+Cin / A-B, one digit per clock, LSD first. Optional macro: BCD_INVALID_CHECK_EN.
// Latency: out_valid rises DIGITS edges after the accept edge; one op per DIGITS+2 cycles at best.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. All outputs registered.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  input  logic                Cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] S,
  output logic                Cout
`ifdef BCD_INVALID_CHECK_EN
  ,
  output logic                err
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t        state, state_nxt;
  logic [W-1:0]  a_q, b_q;
  logic          sub_q;
  logic          carry_q;
  logic [CW-1:0] cnt_q;

  logic          accept;
  logic          step;
  bcd_digit_t    a_cur, b_cur;
  bcd_digit_t    d_digit;
  logic          d_cout;

  // Operands shift right as digits are consumed, so the active digit is always in the low nibble.
  assign a_cur  = a_q[3:0];
  assign b_cur  = b_q[3:0];
  assign accept = (state == IDLE) && in_valid && in_ready;
  assign step   = (state == RUN);

  bcd_digit_addsub u_digit (
    .a     (a_cur),
    .b     (b_cur),
    .cin   (carry_q),
    .sub   (sub_q),
    .digit (d_digit),
    .cout  (d_cout)
  );

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = RUN;
      RUN:     if (cnt_q == LAST)        state_nxt = DONE;
      DONE:    if (out_ready)            state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // State register plus handshake flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  // Operand capture on accept, then one digit per RUN cycle into the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      S       <= '0;
      Cout    <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= B;
      sub_q   <= sub;
      // Subtract is A + nines(B) + 1; Cin has no meaning there.
      carry_q <= sub ? 1'b1 : Cin;
      cnt_q   <= '0;
      S       <= '0;
    end else if (step) begin
      a_q                   <= a_q >> 4;
      b_q                   <= b_q >> 4;
      carry_q               <= d_cout;
      S[{cnt_q, 2'b00} +: 4] <= d_digit;
      cnt_q                 <= cnt_q + 1'b1;
      if (cnt_q == LAST) Cout <= d_cout;
    end
  end

`ifdef BCD_INVALID_CHECK_EN
  // Sticky flag for any non-decimal operand digit seen during the current operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (step) begin
      err <= err | digit_invalid(a_cur) | digit_invalid(b_cur);
    end
  end
`endif

endmodule
